// File: rtl/baud_sched.sv
`default_nettype none
// ============================================================================
//  Module      : baud_sched
//  Description : UART baud scheduler. Divides src_clk into oversample, mid-bit
//                and end-of-bit ticks; divisor updates land on bit boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module baud_sched #(
    parameter int DIV_W       = 16,
    parameter int OVS         = 16,
    parameter int DEFAULT_DIV = 27
) (
    input  logic             src_clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             os_tick,
    output logic             half_tick,
    output logic             bit_tick,
    output logic             div_clk,
    output logic [DIV_W-1:0] cur_div
);

    localparam int               OS_W    = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [OS_W-1:0]  OS_ONE  = OS_W'(1);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVS / 2);
    localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVS / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
    logic [OS_W-1:0]  os_cnt_q,    os_cnt_d;
    logic [DIV_W-1:0] cur_div_q,   cur_div_d;
    logic [DIV_W-1:0] pend_div_q,  pend_div_d;
    logic             pend_valid_q, pend_valid_d;
    logic             os_tick_q,   os_tick_d;
    logic             half_tick_q, half_tick_d;
    logic             bit_tick_q,  bit_tick_d;
    logic             div_clk_q,   div_clk_d;

    logic             w_cfg_fire;
    logic [DIV_W-1:0] w_cfg_val;
    logic             w_running;

    assign w_cfg_fire = cfg_valid & ~pend_valid_q;
    assign w_cfg_val  = (cfg_div == '0) ? DIV_ONE : cfg_div;
    assign w_running  = (state_q == ST_RUN) && en;

    always_comb begin
        state_d      = en ? ST_RUN : ST_IDLE;
        div_cnt_d    = div_cnt_q;
        os_cnt_d     = os_cnt_q;
        cur_div_d    = cur_div_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        os_tick_d    = 1'b0;
        half_tick_d  = 1'b0;
        bit_tick_d   = 1'b0;
        div_clk_d    = 1'b0;

        if (!w_running) begin
            // Stopped, or crossing a stop/start edge: counters restart and any
            // divisor change takes effect at once since no bit is in flight.
            div_cnt_d = '0;
            os_cnt_d  = '0;
            div_clk_d = (state_d == ST_RUN);
            if (pend_valid_q) begin
                cur_div_d    = pend_div_q;
                pend_valid_d = 1'b0;
            end else if (w_cfg_fire) begin
                cur_div_d = w_cfg_val;
            end
        end else begin
            if (bit_tick_q) begin
                if (pend_valid_q) begin
                    cur_div_d    = pend_div_q;
                    pend_valid_d = 1'b0;
                end else if (w_cfg_fire) begin
                    cur_div_d = w_cfg_val;
                end
            end else if (w_cfg_fire) begin
                pend_div_d   = w_cfg_val;
                pend_valid_d = 1'b1;
            end

            if (os_tick_q) begin
                os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_ONE;
            end

            // Compare against the divisor in force next cycle so a boundary
            // switch to a shorter divisor (even 1) times correctly from count 0.
            if (div_cnt_q >= cur_div_d - DIV_ONE) begin
                div_cnt_d   = '0;
                os_tick_d   = 1'b1;
                half_tick_d = (os_cnt_d == OS_MID);
                bit_tick_d  = (os_cnt_d == OS_LAST);
            end else begin
                div_cnt_d = div_cnt_q + DIV_ONE;
            end

            div_clk_d = (os_cnt_d < OS_HALF);
        end
    end

    always_ff @(posedge src_clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            os_cnt_q     <= '0;
            cur_div_q    <= DIV_RST;
            pend_div_q   <= '0;
            pend_valid_q <= 1'b0;
            os_tick_q    <= 1'b0;
            half_tick_q  <= 1'b0;
            bit_tick_q   <= 1'b0;
            div_clk_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            os_cnt_q     <= os_cnt_d;
            cur_div_q    <= cur_div_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            os_tick_q    <= os_tick_d;
            half_tick_q  <= half_tick_d;
            bit_tick_q   <= bit_tick_d;
            div_clk_q    <= div_clk_d;
        end
    end

    assign cfg_ready = ~pend_valid_q;
    assign os_tick   = os_tick_q;
    assign half_tick = half_tick_q;
    assign bit_tick  = bit_tick_q;
    assign div_clk   = div_clk_q;
    assign cur_div   = cur_div_q;

endmodule
`default_nettype wire

// File: tb/tb_baud_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_baud_sched
//  Description : Self-checking bench for baud_sched (DEFAULT_DIV=4, OVS=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_baud_sched;

    localparam int DIV_W = 16;

    logic             src_clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic             os_tick;
    logic             half_tick;
    logic             bit_tick;
    logic             div_clk;
    logic [DIV_W-1:0] cur_div;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int bit_q[$];
    int half_q[$];

    baud_sched #(
        .DIV_W      (DIV_W),
        .OVS        (16),
        .DEFAULT_DIV(4)
    ) dut (
        .src_clk  (src_clk),
        .reset_n  (reset_n),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .os_tick  (os_tick),
        .half_tick(half_tick),
        .bit_tick (bit_tick),
        .div_clk  (div_clk),
        .cur_div  (cur_div)
    );

    always #5 src_clk = ~src_clk;
    always @(posedge src_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge src_clk);
        #1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step(1);
    endtask

    // Scoreboard monitor: every observed bit/half tick consumes one expected time.
    always @(negedge src_clk) begin
        if (bit_q.size() > 0 && cyc > bit_q[0]) begin
            n_total++;
            $display("FAIL bit_tick_missing: got none expected cycle %0d", bit_q.pop_front());
        end
        if (half_q.size() > 0 && cyc > half_q[0]) begin
            n_total++;
            $display("FAIL half_tick_missing: got none expected cycle %0d", half_q.pop_front());
        end
        if (bit_tick) begin
            n_total++;
            if (bit_q.size() == 0)
                $display("FAIL bit_tick_unexpected: got cycle %0d expected none", cyc);
            else if (bit_q[0] == cyc && os_tick) begin
                void'(bit_q.pop_front());
                n_pass++;
            end else
                $display("FAIL bit_tick_time: got cycle %0d os_tick %0b expected cycle %0d os_tick 1",
                         cyc, os_tick, bit_q.pop_front());
        end
        if (half_tick) begin
            n_total++;
            if (half_q.size() == 0)
                $display("FAIL half_tick_unexpected: got cycle %0d expected none", cyc);
            else if (half_q[0] == cyc && os_tick) begin
                void'(half_q.pop_front());
                n_pass++;
            end else
                $display("FAIL half_tick_time: got cycle %0d os_tick %0b expected cycle %0d os_tick 1",
                         cyc, os_tick, half_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t0;

        // Reset state
        step(2);
        reset_n = 1'b1;
        chk("rst_os_tick", os_tick, 0);
        chk("rst_half_tick", half_tick, 0);
        chk("rst_bit_tick", bit_tick, 0);
        chk("rst_div_clk", div_clk, 0);
        chk("rst_cur_div", cur_div, 4);
        chk("rst_cfg_ready", cfg_ready, 1);
        step(2);

        // Divisor 4: os every 4, half at 32, bit at 64
        en = 1'b1; t0 = cyc + 1;
        half_q.push_back(t0 + 32); bit_q.push_back(t0 + 64);
        half_q.push_back(t0 + 96); bit_q.push_back(t0 + 128);
        step_to(t0 + 1);
        chk("t1_div_clk_high", div_clk, 1);
        step_to(t0 + 3);
        chk("t1_os_before_first", os_tick, 0);
        step_to(t0 + 4);
        chk("t1_os_first", os_tick, 1);
        step_to(t0 + 130);
        en = 1'b0;
        step(2);

        // Update 4 -> 8 mid-bit is held until the bit boundary
        en = 1'b1; t0 = cyc + 1;
        half_q.push_back(t0 + 32);  bit_q.push_back(t0 + 64);
        half_q.push_back(t0 + 128); bit_q.push_back(t0 + 192);
        step_to(t0 + 10);
        cfg_valid = 1'b1; cfg_div = 16'd8;
        step_to(t0 + 11);
        cfg_valid = 1'b0;
        chk("t2_ready_low", cfg_ready, 0);
        step_to(t0 + 20);
        cfg_valid = 1'b1; cfg_div = 16'd3;
        step(1);
        cfg_valid = 1'b0;
        step_to(t0 + 64);
        chk("t2_ready_at_bit", cfg_ready, 0);
        chk("t2_div_at_bit", cur_div, 4);
        step_to(t0 + 65);
        chk("t2_ready_back", cfg_ready, 1);
        chk("t2_div_applied", cur_div, 8);
        step_to(t0 + 195);
        en = 1'b0;
        step(2);

        // Idle update applies directly; update on the bit_tick cycle is never pended
        cfg_valid = 1'b1; cfg_div = 16'd4;
        step(1);
        cfg_valid = 1'b0;
        chk("t3_idle_div", cur_div, 4);
        chk("t3_idle_ready", cfg_ready, 1);
        en = 1'b1; t0 = cyc + 1;
        half_q.push_back(t0 + 32);  bit_q.push_back(t0 + 64);
        half_q.push_back(t0 + 80);  bit_q.push_back(t0 + 96);
        half_q.push_back(t0 + 112); bit_q.push_back(t0 + 128);
        step_to(t0 + 64);
        chk("t3_ready_on_bit", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_div = 16'd2;
        step(1);
        cfg_valid = 1'b0;
        chk("t3_ready_after", cfg_ready, 1);
        chk("t3_div_direct", cur_div, 2);
        step_to(t0 + 130);
        en = 1'b0;
        step(2);

        // Divisor 0 maps to 1: os_tick every cycle, bit every 16
        cfg_valid = 1'b1; cfg_div = 16'd0;
        step(1);
        cfg_valid = 1'b0;
        chk("t4_div_zero", cur_div, 1);
        en = 1'b1; t0 = cyc + 1;
        half_q.push_back(t0 + 8);  bit_q.push_back(t0 + 16);
        half_q.push_back(t0 + 24); bit_q.push_back(t0 + 32);
        step_to(t0 + 1);
        chk("t4_os_c1", os_tick, 1);
        step_to(t0 + 2);
        chk("t4_os_c2", os_tick, 1);
        step_to(t0 + 33);
        en = 1'b0;
        step(2);

        // Stop mid-bit with an update pending
        cfg_valid = 1'b1; cfg_div = 16'd4;
        step(1);
        cfg_valid = 1'b0;
        en = 1'b1; t0 = cyc + 1;
        step_to(t0 + 10);
        cfg_valid = 1'b1; cfg_div = 16'd8;
        step(1);
        cfg_valid = 1'b0;
        step_to(t0 + 20);
        chk("t5_div_clk_run", div_clk, 1);
        chk("t5_pending", cfg_ready, 0);
        en = 1'b0;
        step(1);
        chk("t5_os_stop", os_tick, 0);
        chk("t5_div_clk_stop", div_clk, 0);
        chk("t5_div_applied", cur_div, 8);
        chk("t5_ready", cfg_ready, 1);
        step(2);

        // Synchronous reset mid-run with an update pending
        en = 1'b1; t0 = cyc + 1;
        step_to(t0 + 10);
        cfg_valid = 1'b1; cfg_div = 16'd2;
        step(1);
        cfg_valid = 1'b0;
        step_to(t0 + 20);
        reset_n = 1'b0;
        @(negedge src_clk);
        chk("t6_no_async_ready", cfg_ready, 0);
        chk("t6_no_async_div", cur_div, 8);
        chk("t6_no_async_clk", div_clk, 1);
        step(1);
        reset_n = 1'b1;
        en = 1'b0;
        chk("t6_os_tick", os_tick, 0);
        chk("t6_half_tick", half_tick, 0);
        chk("t6_bit_tick", bit_tick, 0);
        chk("t6_div_clk", div_clk, 0);
        chk("t6_cur_div", cur_div, 4);
        chk("t6_cfg_ready", cfg_ready, 1);
        step(3);

        chk("end_bit_q_empty", bit_q.size(), 0);
        chk("end_half_q_empty", half_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
